cpu_step_2: RTL
===============

CPU_STEP_2 -- requirements
Module: cpu_step_2

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits.
REQ-002 Parameter REG_NUMBER, default 32: register-file depth; register index width is $clog2(REG_NUMBER).
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-low.
REQ-005 instr_step_1  input  WIDTH: instruction from fetch.
REQ-006 pc_plus_one_step_1  input  WIDTH: PC+1 from fetch.
REQ-007 flush_step_4  input  1: taken branch/jump; kills the instruction in this stage.
REQ-008 is_mem_read_step_3  input  1: instruction in step 3 is a load.
REQ-009 rd_step_3  input  5: destination register of step 3.
REQ-010 we_step_5, rd_step_5, wdata_step_5  input  1/5/WIDTH: writeback port.
REQ-011 stall_step_2  output  1: high means hold fetch; drives is_load_PC low.
REQ-012 valid_step_2  output  1: stage outputs carry a real instruction.
REQ-013 opcode_step_2  output  6: opcode field.
REQ-014 rd_step_2, rs1_step_2, rs2_step_2  output  5 each: register indices.
REQ-015 rs1_data_step_2, rs2_data_step_2  output  WIDTH each: register operands.
REQ-016 imm_step_2  output  WIDTH: sign-extended immediate.
REQ-017 pc_plus_one_step_2  output  WIDTH: PC+1 of the held instruction.

Function
REQ-018 Instruction fields: opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm [15:0] sign-extended to WIDTH.
REQ-019 The IF/ID register (instr, pc_plus_one, valid) captures step-1 inputs on every rising edge unless stall or flush applies; after reset, valid goes to 1 on the first such capture.
REQ-020 Decode outputs are combinational from the IF/ID register: an instruction fetched in cycle N is presented in cycle N+1.
REQ-021 stall_step_2 = valid AND is_mem_read_step_3 AND rd_step_3 != 0 AND (rd_step_3 == rs1 OR rd_step_3 == rs2), combinational.
REQ-022 While stalled, the IF/ID register holds its contents and valid_step_2 reads 0, which inserts a bubble; the held instruction is presented again on the next cycle.
REQ-023 flush_step_4 clears the IF/ID valid bit at the next edge and overrides stall in the same cycle.
REQ-024 Register file: REG_NUMBER x WIDTH with two asynchronous read ports and one synchronous write port; register 0 reads as 0 and ignores writes.
REQ-025 Write-through bypass: if we_step_5 is high and rd_step_5 (nonzero) matches a read index in the same cycle, that port returns wdata_step_5.
REQ-026 When valid_step_2 is 0, all register-index and opcode outputs read 0 (NOP).

Reset
REQ-027 While rst is low, the IF/ID valid bit, instr, and pc_plus_one are 0, and all register-file entries are 0.
REQ-028 During reset, all outputs are 0 and stall_step_2 is 0.
REQ-029 Reset asserted mid-stall or mid-flush discards the held instruction, with no residual stall after release.

Structure
REQ-030 Shared package cpu_pkg holds the opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_ALU) and the field bit positions.
REQ-031 The register file is a single sub-module, reg_file, instantiated once.

Verification
REQ-032 Reset release, then instr 0x0C22_0005 at PC+1 = 1 -> the next cycle shows valid = 1, opcode = 3, rd = 1, rs1 = 2, imm = 5, pc_plus_one = 1.
REQ-033 Write r3 = 0xDEAD_BEEF via the step-5 port while decoding an instruction with rs1 = 3 -> rs1_data = 0xDEAD_BEEF in the same cycle (bypass).
REQ-034 is_mem_read_step_3 = 1, rd_step_3 = 4, and the decoded rs2 = 4 -> stall = 1 and valid = 0 for one cycle, then the same instruction is presented with stall = 0.
REQ-035 flush_step_4 and a stall condition asserted in the same cycle -> valid = 0 next cycle and no stall.
REQ-036 Write r0 = 0x1234, then read r0 -> 0; pulse rst low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants for the CPU pipeline: opcode values and the
// bit positions of the fixed 32-bit instruction fields.
package cpu_pkg;

   localparam logic [5:0] OP_ALU    = 6'h00;
   localparam logic [5:0] OP_LOAD   = 6'h01;
   localparam logic [5:0] OP_STORE  = 6'h02;
   localparam logic [5:0] OP_BRANCH = 6'h03;
   localparam logic [5:0] OP_JUMP   = 6'h04;

   localparam int OPC_LSB = 26;
   localparam int RD_LSB  = 21;
   localparam int RS1_LSB = 16;
   localparam int RS2_LSB = 11;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 16;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [15:0] imm;
   } fields_t;

   // rs2 overlaps the upper bits of the immediate; both views are kept.
   function automatic fields_t split_instr(input logic [31:0] instr);
      fields_t f;
      f.opcode = instr[OPC_LSB +: 6];
      f.rd     = instr[RD_LSB  +: 5];
      f.rs1    = instr[RS1_LSB +: 5];
      f.rs2    = instr[RS2_LSB +: 5];
      f.imm    = instr[IMM_LSB +: IMM_W];
      return f;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports with write-through bypass,
// one synchronous write port; entry 0 is hard-wired to zero.
module reg_file #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    raddr1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata1,
   output logic [WIDTH-1:0] rdata2,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_ok;

   assign wr_ok = we && (waddr != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (raddr1 != '0) begin
         rdata1 = (wr_ok && waddr == raddr1) ? wdata : mem[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (raddr2 != '0) begin
         rdata2 = (wr_ok && waddr == raddr2) ? wdata : mem[raddr2];
      end
   end

endmodule

// File: rtl/cpu_step_2.sv
// Decode stage: IF/ID pipeline register, load-use hazard detection with
// bubble insertion, flush handling, field decode and register operand read.
module cpu_step_2
   import cpu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int REG_NUMBER = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr_step_1,
   input  logic [WIDTH-1:0] pc_plus_one_step_1,
   input  logic             flush_step_4,
   input  logic             is_mem_read_step_3,
   input  logic [4:0]       rd_step_3,
   input  logic             we_step_5,
   input  logic [4:0]       rd_step_5,
   input  logic [WIDTH-1:0] wdata_step_5,
   output logic             stall_step_2,
   output logic             valid_step_2,
   output logic [5:0]       opcode_step_2,
   output logic [4:0]       rd_step_2,
   output logic [4:0]       rs1_step_2,
   output logic [4:0]       rs2_step_2,
   output logic [WIDTH-1:0] rs1_data_step_2,
   output logic [WIDTH-1:0] rs2_data_step_2,
   output logic [WIDTH-1:0] imm_step_2,
   output logic [WIDTH-1:0] pc_plus_one_step_2
);

   localparam int AW = $clog2(REG_NUMBER);

   logic [WIDTH-1:0] instr_q;
   logic [WIDTH-1:0] pc_q;
   logic             valid_q;
   fields_t          f;
   logic             hazard;
   logic             live;

   assign f = split_instr(instr_q[31:0]);

   // Hazard uses the raw held fields, not the NOP-masked outputs, so the
   // masking below cannot feed back into the stall decision.
   assign hazard = valid_q && is_mem_read_step_3 && (rd_step_3 != 5'd0) &&
                   ((rd_step_3 == f.rs1) || (rd_step_3 == f.rs2));

   assign live = valid_q && !hazard;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_step_4) begin
         valid_q <= 1'b0;
      end else if (!hazard) begin
         instr_q <= instr_step_1;
         pc_q    <= pc_plus_one_step_1;
         valid_q <= 1'b1;
      end
   end

   reg_file #(
      .WIDTH (WIDTH),
      .DEPTH (REG_NUMBER),
      .AW    (AW)
   ) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (f.rs1[AW-1:0]),
      .raddr2 (f.rs2[AW-1:0]),
      .rdata1 (rs1_data_step_2),
      .rdata2 (rs2_data_step_2),
      .we     (we_step_5),
      .waddr  (rd_step_5[AW-1:0]),
      .wdata  (wdata_step_5)
   );

   assign stall_step_2       = hazard;
   assign valid_step_2       = live;
   assign opcode_step_2      = live ? f.opcode : 6'd0;
   assign rd_step_2          = live ? f.rd     : 5'd0;
   assign rs1_step_2         = live ? f.rs1    : 5'd0;
   assign rs2_step_2         = live ? f.rs2    : 5'd0;
   assign imm_step_2         = {{(WIDTH-IMM_W){f.imm[IMM_W-1]}}, f.imm};
   assign pc_plus_one_step_2 = pc_q;

endmodule
